// File: rtl/ppu_timing_gen_if.sv
// Host/render-side signal bundle of the PPU timing generator.
// master: the timing generator itself; slave: the register/render logic that consumes it.
interface ppu_timing_gen_if #(
    parameter int CNT_W = 9
);
    logic             I_rendering;
    logic             I_nmi_enable;
    logic             I_status_rd;
    logic             O_dot_en;
    logic [CNT_W-1:0] O_x;
    logic [CNT_W-1:0] O_y;
    logic             O_hsync;
    logic             O_vsync;
    logic             O_active;
    logic             O_line_start;
    logic             O_frame_start;
    logic             O_frame_odd;
    logic             O_vblank;
    logic             O_host_nmi;

    // No valid/ready handshake here: I_status_rd is a single-clock strobe, and O_dot_en,
    // O_line_start and O_frame_start are single-clock pulses. All other signals are levels.
    modport master (
        input  I_rendering, I_nmi_enable, I_status_rd,
        output O_dot_en, O_x, O_y, O_hsync, O_vsync, O_active,
        output O_line_start, O_frame_start, O_frame_odd, O_vblank, O_host_nmi
    );

    modport slave (
        output I_rendering, I_nmi_enable, I_status_rd,
        input  O_dot_en, O_x, O_y, O_hsync, O_vsync, O_active,
        input  O_line_start, O_frame_start, O_frame_odd, O_vblank, O_host_nmi
    );
endinterface

// File: rtl/ppu_timing_gen.sv
// PPU dot/line timing generator with VBL flag and NMI generation.
// Define PPU_TIMING_ODD_SKIP_EN to drop the last pre-render dot on odd rendering frames.
module ppu_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int CNT_W       = 9,
    parameter int H_TOTAL     = 341,
    parameter int V_TOTAL     = 262,
    parameter int H_VISIBLE   = 256,
    parameter int V_VISIBLE   = 240,
    parameter int VBL_LINE    = 241,
    parameter int HSYNC_START = 275,
    parameter int HSYNC_END   = 300,
    parameter int VSYNC_START = 242,
    parameter int VSYNC_END   = 244
) (
    input  logic                 I_clock,
    input  logic                 I_reset,
    ppu_timing_gen_if.master     bus
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_SKIP   = CNT_W'(H_TOTAL - 2);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VBL    = CNT_W'(VBL_LINE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(HSYNC_START);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_END);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(VSYNC_START);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VSYNC_END);
    localparam logic [CNT_W-1:0] X_ONE    = CNT_W'(1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             odd_q, odd_d;
    logic             vbl_q, vbl_d;
    logic             sup_q, sup_d;

    logic dot_en;
    logic at_set;
    logic at_clr;
    logic at_race;
    logic skip;

    assign dot_en  = (div_q == DIV_LAST);
    assign at_set  = (x_q == X_ONE) && (y_q == Y_VBL);
    assign at_clr  = (x_q == X_ONE) && (y_q == Y_LAST);
    assign at_race = (x_q == '0) && (y_q == Y_VBL);

`ifdef PPU_TIMING_ODD_SKIP_EN
    assign skip = odd_q && bus.I_rendering && (y_q == Y_LAST) && (x_q == X_SKIP);
`else
    logic unused_rendering;
    assign unused_rendering = bus.I_rendering;
    assign skip = 1'b0;
`endif

    always_comb begin
        div_d = dot_en ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        odd_d = odd_q;
        vbl_d = vbl_q;
        sup_d = sup_q;
        if (dot_en) begin
            if (skip) begin
                x_d   = '0;
                y_d   = '0;
                odd_d = ~odd_q;
            end else if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d   = '0;
                    odd_d = ~odd_q;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
            if (at_set && !sup_q) vbl_d = 1'b1;
            if (at_clr) begin
                vbl_d = 1'b0;
                sup_d = 1'b0;
            end
        end
        // A status read always wins over a same-clock set; a read one dot early kills the whole frame's VBL.
        if (bus.I_status_rd) begin
            vbl_d = 1'b0;
            if (at_race) sup_d = 1'b1;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            odd_q <= 1'b0;
            vbl_q <= 1'b0;
            sup_q <= 1'b0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            odd_q <= odd_d;
            vbl_q <= vbl_d;
            sup_q <= sup_d;
        end
    end

    assign bus.O_dot_en      = dot_en;
    assign bus.O_x           = x_q;
    assign bus.O_y           = y_q;
    assign bus.O_hsync       = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    assign bus.O_vsync       = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    assign bus.O_active      = (x_q != '0) && (x_q <= X_VIS) && (y_q < Y_VIS);
    assign bus.O_line_start  = dot_en && (x_q == '0);
    assign bus.O_frame_start = dot_en && (x_q == '0) && (y_q == '0);
    assign bus.O_frame_odd   = odd_q;
    assign bus.O_vblank      = vbl_q;
    assign bus.O_host_nmi    = !(vbl_q && bus.I_nmi_enable);
endmodule

// File: tb/tb_ppu_timing_gen.sv
// Directed bench for ppu_timing_gen on a reduced 40x20-dot geometry with CLK_DIV=4.
// Expected frame length follows PPU_TIMING_ODD_SKIP_EN when the bench is built with it.
module tb_ppu_timing_gen;
  localparam int CNT_W = 9;
  localparam int DIV   = 4;
  localparam int GOTO_LIMIT = 8000;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned cyc_f;
  int n_pass;
  int n_total;
  int cnt;

  ppu_timing_gen_if #(.CNT_W(CNT_W)) bus ();

  ppu_timing_gen #(
    .CLK_DIV(DIV), .CNT_W(CNT_W), .H_TOTAL(40), .V_TOTAL(20),
    .H_VISIBLE(32), .V_VISIBLE(15), .VBL_LINE(16),
    .HSYNC_START(34), .HSYNC_END(37), .VSYNC_START(17), .VSYNC_END(18)
  ) dut (
    .I_clock(clk),
    .I_reset(rst_n),
    .bus(bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dot();
    int n;
    n = 0;
    step();
    while (!bus.O_dot_en && n < 3 * DIV) begin
      step();
      n++;
    end
    if (!bus.O_dot_en) begin
      n_total++;
      $error("FAIL wait_dot: observed no dot_en expected dot_en within %0d clocks", 3 * DIV);
    end
  endtask

  task automatic goto(input int tx, input int ty);
    int n;
    n = 0;
    while (!(bus.O_dot_en && bus.O_x == tx[CNT_W-1:0] && bus.O_y == ty[CNT_W-1:0]) && n < GOTO_LIMIT) begin
      step();
      n++;
    end
    if (n >= GOTO_LIMIT) begin
      n_total++;
      $error("FAIL goto: observed x=%0d y=%0d expected x=%0d y=%0d", bus.O_x, bus.O_y, tx, ty);
    end
  endtask

  task automatic pulse_rd();
    bus.I_status_rd = 1'b1;
    step();
    bus.I_status_rd = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.I_rendering = 1'b0;
    bus.I_nmi_enable = 1'b1;
    bus.I_status_rd = 1'b0;
    repeat (3) step();

    // reset state
    chk1("rst_dot_en", bus.O_dot_en, 1'b0);
    chkn("rst_x", 32'(bus.O_x), 32'd0);
    chkn("rst_y", 32'(bus.O_y), 32'd0);
    chk1("rst_hsync", bus.O_hsync, 1'b1);
    chk1("rst_vsync", bus.O_vsync, 1'b1);
    chk1("rst_active", bus.O_active, 1'b0);
    chk1("rst_line_start", bus.O_line_start, 1'b0);
    chk1("rst_frame_start", bus.O_frame_start, 1'b0);
    chk1("rst_frame_odd", bus.O_frame_odd, 1'b0);
    chk1("rst_vblank", bus.O_vblank, 1'b0);
    chk1("rst_host_nmi", bus.O_host_nmi, 1'b1);

    // first dot after release: divider counts 0,1,2,3
    rst_n = 1'b1;
    step();
    step();
    chk1("first_dot_early", bus.O_dot_en, 1'b0);
    step();
    chk1("first_dot", bus.O_dot_en, 1'b1);
    chk1("first_frame_start", bus.O_frame_start, 1'b1);
    chk1("first_line_start", bus.O_line_start, 1'b1);
    cyc_f = cyc;
    step();
    chk1("dot_en_low", bus.O_dot_en, 1'b0);
    chkn("x_after_dot", 32'(bus.O_x), 32'd1);
    chk1("active_x1_y0", bus.O_active, 1'b1);
    cnt = 1;
    while (!bus.O_dot_en && cnt < 20) begin
      step();
      cnt++;
    end
    chkn("dot_period", 32'(cnt), 32'd4);

    // frame 0: horizontal decodes
    goto(32, 0);
    chk1("active_x32", bus.O_active, 1'b1);
    goto(33, 0);
    chk1("active_x33", bus.O_active, 1'b0);
    chk1("hsync_x33", bus.O_hsync, 1'b1);
    goto(34, 0);
    chk1("hsync_x34", bus.O_hsync, 1'b0);
    goto(37, 0);
    chk1("hsync_x37", bus.O_hsync, 1'b0);
    goto(38, 0);
    chk1("hsync_x38", bus.O_hsync, 1'b1);
    goto(0, 1);
    chk1("line_start_y1", bus.O_line_start, 1'b1);
    chk1("frame_start_y1", bus.O_frame_start, 1'b0);
    cnt = 0;
    do begin
      wait_dot();
      cnt++;
    end while (!bus.O_line_start && cnt < 100);
    chkn("line_dots", 32'(cnt), 32'd40);

    // vertical window and VBL set / read clear
    goto(1, 14);
    chk1("active_y14", bus.O_active, 1'b1);
    goto(1, 15);
    chk1("active_y15", bus.O_active, 1'b0);
    goto(1, 16);
    chk1("vbl_before_set", bus.O_vblank, 1'b0);
    step();
    chk1("vbl_set", bus.O_vblank, 1'b1);
    chk1("nmi_on_set", bus.O_host_nmi, 1'b0);
    goto(10, 16);
    pulse_rd();
    chk1("vbl_read_clear", bus.O_vblank, 1'b0);
    chk1("nmi_read_clear", bus.O_host_nmi, 1'b1);
    goto(39, 16);
    chk1("vsync_y16", bus.O_vsync, 1'b1);
    goto(0, 17);
    chk1("vsync_y17", bus.O_vsync, 1'b0);
    goto(39, 18);
    chk1("vsync_y18", bus.O_vsync, 1'b0);
    goto(0, 19);
    chk1("vsync_y19", bus.O_vsync, 1'b1);
    goto(0, 0);
    chk1("f1_frame_start", bus.O_frame_start, 1'b1);
    chk1("f1_frame_odd", bus.O_frame_odd, 1'b1);
    chkn("f0_clocks", cyc - cyc_f, 32'd3200);
    cyc_f = cyc;
    bus.I_rendering = 1'b1;

    // frame 1 (odd): read one dot before the set point suppresses VBL
    goto(39, 15);
    step();
    pulse_rd();
    goto(2, 16);
    chk1("sup_vbl", bus.O_vblank, 1'b0);
    chk1("sup_nmi", bus.O_host_nmi, 1'b1);
    goto(5, 18);
    chk1("sup_vbl_late", bus.O_vblank, 1'b0);
    goto(38, 19);
    wait_dot();
`ifdef PPU_TIMING_ODD_SKIP_EN
    chkn("skip_x", 32'(bus.O_x), 32'd0);
    chkn("skip_y", 32'(bus.O_y), 32'd0);
    chk1("skip_frame_start", bus.O_frame_start, 1'b1);
    chk1("skip_frame_odd", bus.O_frame_odd, 1'b0);
    chkn("f1_clocks", cyc - cyc_f, 32'd3196);
`else
    chkn("noskip_x", 32'(bus.O_x), 32'd39);
    chkn("noskip_y", 32'(bus.O_y), 32'd19);
    chk1("noskip_frame_start", bus.O_frame_start, 1'b0);
    goto(0, 0);
    chk1("noskip_frame_odd", bus.O_frame_odd, 1'b0);
    chkn("f1_clocks", cyc - cyc_f, 32'd3200);
`endif
    cyc_f = cyc;

    // frame 2 (even): read on the same clock as the set dot wins
    goto(1, 16);
    pulse_rd();
    chk1("race_set_vbl", bus.O_vblank, 1'b0);
    chk1("race_set_nmi", bus.O_host_nmi, 1'b1);
    goto(5, 17);
    chk1("race_set_vbl_late", bus.O_vblank, 1'b0);
    goto(0, 0);
    chkn("f2_clocks", cyc - cyc_f, 32'd3200);
    chk1("f3_frame_odd", bus.O_frame_odd, 1'b1);

    // frame 3 (odd): late NMI enable, then reset mid-VBL
    bus.I_nmi_enable = 1'b0;
    goto(1, 16);
    step();
    chk1("vbl_set_nmi_off", bus.O_vblank, 1'b1);
    chk1("nmi_disabled", bus.O_host_nmi, 1'b1);
    goto(5, 17);
    bus.I_nmi_enable = 1'b1;
    #1;
    chk1("nmi_late_enable", bus.O_host_nmi, 1'b0);
    goto(10, 18);
    rst_n = 1'b0;
    #1;
    chkn("mid_rst_x", 32'(bus.O_x), 32'd0);
    chkn("mid_rst_y", 32'(bus.O_y), 32'd0);
    chk1("mid_rst_vblank", bus.O_vblank, 1'b0);
    chk1("mid_rst_nmi", bus.O_host_nmi, 1'b1);
    chk1("mid_rst_vsync", bus.O_vsync, 1'b1);
    chk1("mid_rst_frame_odd", bus.O_frame_odd, 1'b0);
    chk1("mid_rst_dot_en", bus.O_dot_en, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    chk1("rel_dot_early", bus.O_dot_en, 1'b0);
    step();
    chk1("rel_dot", bus.O_dot_en, 1'b1);
    chk1("rel_frame_start", bus.O_frame_start, 1'b1);
    chk1("rel_frame_odd", bus.O_frame_odd, 1'b0);

    // post-reset frame: normal set, then self-clear on the pre-render line
    goto(1, 16);
    step();
    chk1("post_vbl_set", bus.O_vblank, 1'b1);
    chk1("post_nmi_set", bus.O_host_nmi, 1'b0);
    goto(1, 19);
    chk1("pre_clear_vbl", bus.O_vblank, 1'b1);
    step();
    chk1("self_clear_vbl", bus.O_vblank, 1'b0);
    chk1("self_clear_nmi", bus.O_host_nmi, 1'b1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ppu_timing_gen.md
Name: ppu_timing_gen

Overview:
- Parametrised dot/line timing generator and status-flag engine for the PPU.
- Divides the master clock into a dot-rate enable and produces dot (x) and scanline (y) counters, sync/blank strobes, an odd/even frame flag and the VBL status flag.
- Generates the active-low NMI and suppresses it on a VBL read race.
- Sits between the master clock domain and the PPU register/render logic; supports NTSC/PAL geometries by parameter and adds odd-frame dot skipping.

Parameters:
- CLK_DIV, 4, master clocks per dot; legal values 2..16.
- CNT_W, 9, width of the x and y counters.
- H_TOTAL, 341, dots per scanline.
- V_TOTAL, 262, scanlines per frame; pre-render line = V_TOTAL-1.
- H_VISIBLE, 256, visible dots; visible x range is 1..H_VISIBLE.
- V_VISIBLE, 240, visible lines; visible y range is 0..V_VISIBLE-1.
- VBL_LINE, 241, line on which VBL is set.
- HSYNC_START, 275, first dot of the hsync pulse.
- HSYNC_END, 300, last dot of the hsync pulse.
- VSYNC_START, 242, first line of the vsync pulse.
- VSYNC_END, 244, last line of the vsync pulse.

Ports:
- I_clock  in  1  master clock.
- I_reset  in  1  asynchronous reset, active-low.
- I_rendering  in  1  background-or-sprite enable; level, sampled on dot_en.
- I_nmi_enable  in  1  control-register NMI enable bit.
- I_status_rd  in  1  one-clock strobe: host read of the status register.
- O_dot_en  out  1  one-clock pulse per dot.
- O_x  out  CNT_W  current dot.
- O_y  out  CNT_W  current scanline.
- O_hsync  out  1  active-low horizontal sync.
- O_vsync  out  1  active-low vertical sync.
- O_active  out  1  visible-pixel window.
- O_line_start  out  1  dot_en pulse at x==0.
- O_frame_start  out  1  dot_en pulse at x==0, y==0.
- O_frame_odd  out  1  odd-frame flag.
- O_vblank  out  1  VBL status flag, for the status-read mux.
- O_host_nmi  out  1  active-low NMI.

Behaviour:
- Reset (async, active-low): divider=0, x=0, y=0, frame_odd=0, vblank=0, suppress=0. All pulses 0, O_hsync=1, O_vsync=1, O_active=0, O_host_nmi=1. Reset mid-frame restarts at (0,0) on the first dot after release.
- Divider:
  - counts 0..CLK_DIV-1 and wraps;
  - O_dot_en=1 exactly when divider==CLK_DIV-1, so there is one pulse per CLK_DIV clocks;
  - the first pulse occurs CLK_DIV clocks after reset release.
- Counters advance only on dot_en; all outputs below are registered and update on the same clock as the counters.
  - x increments; at x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1, y wraps to 0 and frame_odd toggles.
- Odd-frame skip (see Optional Feature): if frame_odd==1, I_rendering==1, y==V_TOTAL-1 and x==H_TOTAL-2, the next dot is (0,0). The dot H_TOTAL-1 is skipped.
- Combinational decodes from the registered x/y:
  - O_hsync = !(HSYNC_START<=x<=HSYNC_END).
  - O_vsync = !(VSYNC_START<=y<=VSYNC_END).
  - O_active = (1<=x<=H_VISIBLE) && (y<V_VISIBLE).
  - O_line_start and O_frame_start are gated with dot_en.
- VBL flag:
  - set on the dot_en where (x==1, y==VBL_LINE) unless suppress==1;
  - cleared on the dot_en where (x==1, y==V_TOTAL-1).
- Status read:
  - I_status_rd clears vblank on the next clock.
  - If I_status_rd arrives while (x==0, y==VBL_LINE), suppress is set, so that frame neither sets VBL nor raises NMI. suppress clears at the pre-render clear point.
  - Read on the same clock as the set dot_en: read wins, vblank stays 0, no NMI.
  - Read on the same clock as the clear dot_en: vblank=0.
- NMI:
  - O_host_nmi = !(vblank & I_nmi_enable), combinational.
  - Toggling I_nmi_enable 0→1 while vblank=1 produces a new falling edge.
- No arithmetic overflow: counters never exceed H_TOTAL-1 / V_TOTAL-1. CNT_W must hold max(H_TOTAL, V_TOTAL)-1.

Optional Feature:
- Macro: PPU_TIMING_ODD_SKIP_EN.
- Defined: the odd-frame skip above is active.
- Undefined: every frame is H_TOTAL*V_TOTAL dots regardless of I_rendering. O_frame_odd still toggles each frame.

Test Plan:
- Release reset, hold I_rendering=0, defaults → O_dot_en every 4 clocks; O_frame_start period 341*262*4 = 357368 clocks; O_hsync low for x=275..300 (26 dots), O_vsync low for y=242..244.
- Defaults, macro defined, I_rendering=1 → even frame 89342 dots, odd frame 89341 dots. On the odd pre-render line x goes 339→0 and y goes 261→0. Repeat with macro undefined → all frames 89342 dots.
- I_nmi_enable=1 → O_vblank rises at dot_en (x=1, y=241); O_host_nmi falls on the same clock. Pulse I_status_rd at (x=10, y=241) → vblank=0 and O_host_nmi=1 one clock later.
- I_status_rd during (x=0, y=241) → vblank stays 0 for the entire frame and O_host_nmi stays 1. Next frame sets normally at (1,241).
- Hold I_nmi_enable=0 through (1,241), then set it to 1 at (5,250) → O_host_nmi falls that clock. Vblank self-clears at (1,261) → O_host_nmi returns to 1.
- Assert I_reset low at (100,120) for 3 clocks → all outputs return to reset values immediately. After release, first O_dot_en after 4 clocks at x=0, y=0 with O_frame_start=1. O_frame_odd=0.
